// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scan driver:
// register selects, digit count, blank code and the hex glyph table.
package seg7_pkg;

    typedef enum logic [1:0] {
        REG_VAL_LO = 2'b00,
        REG_CTRL   = 2'b01,
        REG_VAL_HI = 2'b10,
        REG_NONE   = 2'b11
    } seg7_reg_e;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [7:0] BLANK_CODE = 8'hFF;

    // Active-low glyphs, bit0=a .. bit6=g, bit7=dp (always off). Entry 15 first.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern (dp off).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Memory-mapped 8-digit multiplexed seven-segment driver on the CPU IO bus.
// Optional blink support is built when SEG7_BLINK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 8000000
) (
    input  logic                  segclk,
    input  logic                  segrst,
    input  logic                  segwrite,
    input  logic                  segcs,
    input  logic [1:0]            segaddr,
    input  logic [15:0]           seginputdata,
    output logic [NUM_DIGITS-1:0] seg_an,
    output logic [7:0]            seg_out
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("BLINK_DIV must be at least 2");
    end

    logic [31:0]           value;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic                  blink_phase;
    logic [SCAN_W-1:0]     cnt;
    logic [IDX_W-1:0]      idx;
    logic                  wr_en;
    logic                  dark;
    logic [7:0]            glyph;

    assign wr_en = segwrite & segcs;

    // NOTE: every clocked process uses non-blocking assignments so all
    // registers sample the pre-edge values and no ordering race exists.
    always_ff @(posedge segclk) begin
        if (segrst) begin
            value      <= '0;
            blank_mask <= '0;
        end else if (wr_en) begin
            case (seg7_reg_e'(segaddr))
                REG_VAL_LO: value[15:0]  <= seginputdata;
                REG_VAL_HI: value[31:16] <= seginputdata;
                REG_CTRL:   blank_mask   <= seginputdata[7:0];
                default:    ;
            endcase
        end
    end

    // Digit hold counter; idx wraps 7 -> 0 through natural overflow.
    always_ff @(posedge segclk) begin
        if (segrst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == SCAN_LAST) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;

    // Free-running phase, deliberately not aligned to the digit scan.
    always_ff @(posedge segclk) begin
        if (segrst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_mask  <= '0;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (wr_en && (seg7_reg_e'(segaddr) == REG_CTRL)) begin
                blink_mask <= seginputdata[15:8];
            end
        end
    end
`else
    assign blink_mask  = '0;
    assign blink_phase = 1'b0;
`endif

    assign dark = blank_mask[idx] | (blink_mask[idx] & blink_phase);

    seg7_hex_decode u_decode (
        .nibble (value[{idx, 2'b00} +: 4]),
        .seg    (glyph)
    );

    always_ff @(posedge segclk) begin
        if (segrst) begin
            seg_an  <= '1;
            seg_out <= BLANK_CODE;
        end else begin
            seg_an  <= ~(NUM_DIGITS'(1) << idx);
            seg_out <= dark ? BLANK_CODE : glyph;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV=4, BLINK_DIV=16):
// a scoreboard queue of expected digits drained by a digit-change monitor.
module tb_seg7_scan_driver;

    logic        segclk       = 1'b0;
    logic        segrst       = 1'b1;
    logic        segwrite     = 1'b0;
    logic        segcs        = 1'b0;
    logic [1:0]  segaddr      = 2'b00;
    logic [15:0] seginputdata = 16'h0000;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    bit mon_en  = 1'b1;
    logic [7:0] prev_an = 8'hFF;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    seg7_scan_driver #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16)
    ) dut (
        .segclk       (segclk),
        .segrst       (segrst),
        .segwrite     (segwrite),
        .segcs        (segcs),
        .segaddr      (segaddr),
        .seginputdata (seginputdata),
        .seg_an       (seg_an),
        .seg_out      (seg_out)
    );

    always #5 segclk = ~segclk;

    // Edges since reset release: after edge k the DUT shows digit ((k-1)/4)%8.
    always @(posedge segclk) begin
        if (segrst) edge_n = 0;
        else        edge_n = edge_n + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Monitor: each new digit presented on seg_an consumes one expectation.
    always @(negedge segclk) begin
        if (mon_en && (seg_an !== prev_an)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_unexpected: got an=%02h seg=%02h, expected no further digit", seg_an, seg_out);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, "_an"},  seg_an,  mon_e.an);
                check({mon_e.tag, "_seg"}, seg_out, mon_e.seg);
            end
        end
        prev_an = seg_an;
    end

    task automatic push_frame(input string name, input logic [63:0] segs);
        for (int d = 0; d < 8; d++) begin
            exp_t e;
            e.an  = ~(8'd1 << d);
            e.seg = segs[8*d +: 8];
            e.tag = $sformatf("%s_d%0d", name, d);
            exp_q.push_back(e);
        end
    endtask

    task automatic goto(input int k);
        int budget = 1000;
        while (edge_n < k && budget > 0) begin
            @(posedge segclk);
            #1;
            budget--;
        end
    endtask

    // Drive a bus cycle so that it is sampled at edge at_edge.
    task automatic bus_write(input int at_edge, input logic we, input logic cs,
                             input logic [1:0] addr, input logic [15:0] data);
        goto(at_edge - 1);
        segwrite     = we;
        segcs        = cs;
        segaddr      = addr;
        seginputdata = data;
        goto(at_edge);
        segwrite     = 1'b0;
        segcs        = 1'b0;
        segaddr      = 2'b00;
        seginputdata = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Frames starting at edges 1, 33, 65 and 97.
        push_frame("idle",  {8{8'hC0}});
        push_frame("val",   {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0});
        push_frame("blank", {8'hFF, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF});
        push_frame("hold",  {8'hFF, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF});

        repeat (3) begin
            @(posedge segclk);
            #1;
            check("reset_an",  seg_an,  8'hFF);
            check("reset_seg", seg_out, 8'hFF);
        end
        segrst = 1'b0;

        goto(1);
        check("first_an",  seg_an,  8'hFE);
        check("first_seg", seg_out, 8'hC0);

        bus_write(33, 1'b1, 1'b1, 2'b00, 16'h3210);
        bus_write(34, 1'b1, 1'b1, 2'b10, 16'h7654);
        bus_write(63, 1'b1, 1'b1, 2'b01, 16'h0081);
        bus_write(66, 1'b1, 1'b1, 2'b11, 16'hFFFF);
        bus_write(67, 1'b1, 1'b0, 2'b00, 16'hFFFF);
        bus_write(68, 1'b1, 1'b0, 2'b01, 16'h0000);
        bus_write(69, 1'b0, 1'b1, 2'b10, 16'h0000);

        goto(126);
        mon_en = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        // Write latency on the selected digit 0 (edges 129..132).
        bus_write(127, 1'b1, 1'b1, 2'b01, 16'h0000);
        bus_write(130, 1'b1, 1'b1, 2'b00, 16'h000F);
        check("lat_an",     seg_an,  8'hFE);
        check("lat_before", seg_out, 8'hC0);
        goto(131);
        check("lat_after",  seg_out, 8'h8E);

        // Blink: digits 0-3 always land in phase 0, digits 4-7 in phase 1.
        bus_write(132, 1'b1, 1'b1, 2'b01, 16'h2200);
        goto(134);
        check("blink_d1_an",  seg_an,  8'hFD);
        check("blink_d1_seg", seg_out, 8'hC0);
        goto(146);
        check("blink_d4_an",  seg_an,  8'hEF);
        check("blink_d4_seg", seg_out, 8'h99);
        goto(150);
        check("blink_d5_an",  seg_an,  8'hDF);
`ifdef SEG7_BLINK_EN
        check("blink_d5_seg", seg_out, 8'hFF);
`else
        check("blink_d5_seg", seg_out, 8'h92);
`endif
        goto(166);
        check("blink_d1b_an",  seg_an,  8'hFD);
        check("blink_d1b_seg", seg_out, 8'hC0);

        // One-cycle reset sampled while idx=5, cnt=2.
        goto(182);
        segrst = 1'b1;
        @(posedge segclk);
        #1;
        segrst = 1'b0;
        check("midrst_an",  seg_an,  8'hFF);
        check("midrst_seg", seg_out, 8'hFF);
        goto(1);
        check("post_d0_an",  seg_an,  8'hFE);
        check("post_d0_seg", seg_out, 8'hC0);
        goto(5);
        check("post_d1_an",  seg_an,  8'hFD);
        check("post_d1_seg", seg_out, 8'hC0);
        goto(17);
        check("post_d4_an",  seg_an,  8'hEF);
        check("post_d4_seg", seg_out, 8'hC0);
        goto(21);
        check("post_d5_an",  seg_an,  8'hDF);
        check("post_d5_seg", seg_out, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
